// File: rtl/pc_fetch_ctrl.sv
// Program-counter and instruction-fetch controller: issues one fetch per PC,
// holds the fetched word for decode, and picks the next PC on each handshake.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  pc_source,
    input  logic [31:0] jalr_addr,
    input  logic [31:0] branch_addr,
    input  logic [31:0] jal_addr,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] prog_count,
    output logic [31:0] pc_plus4,
    output logic        misaligned,
    output logic [31:0] bad_addr
);

    typedef enum logic {FETCH = 1'b0, VALID = 1'b1} state_t;

    state_t      state, state_nxt;
    logic        handshake;
    logic [31:0] target;
    logic        target_bad;

    assign handshake = (state == VALID) && instr_ready;
    assign pc_plus4  = prog_count + 32'd4;
    assign imem_addr = prog_count;

    always_ff @(posedge clk) begin
        if (rst) state <= FETCH;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FETCH:   if (imem_ack)    state_nxt = VALID;
            VALID:   if (instr_ready) state_nxt = FETCH;
            default: state_nxt = FETCH;
        endcase
    end

    always_comb begin
        imem_req    = (state == FETCH);
        instr_valid = (state == VALID);
    end

    // jalr drops bit 0, so any low bit still set on the chosen target is a fault
    always_comb begin
        target = pc_plus4;
        case (pc_source)
            3'd1:    target = {jalr_addr[31:1], 1'b0};
            3'd2:    target = branch_addr;
            3'd3:    target = jal_addr;
            3'd4:    target = mtvec;
            3'd5:    target = mepc;
            default: target = pc_plus4;
        endcase
        target_bad = target[1] | target[0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prog_count <= RESET_VECTOR;
            instr      <= 32'h0;
            misaligned <= 1'b0;
            bad_addr   <= 32'h0;
        end else begin
            misaligned <= 1'b0;
            if (state == FETCH && imem_ack)
                instr <= imem_rdata;
            if (handshake) begin
                if (target_bad) begin
                    prog_count <= {mtvec[31:2], 2'b00};
                    misaligned <= 1'b1;
                    bad_addr   <= target;
                end else begin
                    prog_count <= target;
                end
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboard bench for pc_fetch_ctrl: expected fetch addresses are queued when
// a handshake is driven and compared when the controller issues the fetch.
module tb_pc_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  pc_source;
    logic [31:0] jalr_addr, branch_addr, jal_addr, mtvec, mepc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] prog_count, pc_plus4;
    logic        misaligned;
    logic [31:0] bad_addr;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_bad;

    always #5 clk = ~clk;

    pc_fetch_ctrl dut (
        .clk(clk), .rst(rst), .pc_source(pc_source),
        .jalr_addr(jalr_addr), .branch_addr(branch_addr), .jal_addr(jal_addr),
        .mtvec(mtvec), .mepc(mepc),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .prog_count(prog_count), .pc_plus4(pc_plus4),
        .misaligned(misaligned), .bad_addr(bad_addr)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference next-PC choice, written from the selection rules directly.
    function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [2:0] src,
                                               input logic [31:0] jr, input logic [31:0] br,
                                               input logic [31:0] jl, input logic [31:0] tv,
                                               input logic [31:0] ep, output logic bad,
                                               output logic [31:0] tgt);
        case (src)
            3'd1:    tgt = jr & 32'hFFFF_FFFE;
            3'd2:    tgt = br;
            3'd3:    tgt = jl;
            3'd4:    tgt = tv;
            3'd5:    tgt = ep;
            default: tgt = pc + 32'd4;
        endcase
        bad = (tgt[1:0] != 2'b00);
        return bad ? (tv & 32'hFFFF_FFFC) : tgt;
    endfunction

    // Wait nwait cycles in FETCH, then ack; checks address each cycle and the VALID result.
    task automatic fetch_word(input logic [31:0] rdata, input int nwait);
        logic [31:0] exp;
        if (exp_addr_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_empty: no expected fetch address queued");
            return;
        end
        exp = exp_addr_q[0];
        for (int i = 0; i <= nwait; i++) begin
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== exp || instr_valid !== 1'b0) begin
                errors++;
                $display("FAIL fetch_addr: req=%b addr=%h valid=%b, expected req=1 addr=%h valid=0",
                         imem_req, imem_addr, instr_valid, exp);
            end
            if (i == nwait) begin
                imem_ack   = 1'b1;
                imem_rdata = rdata;
            end
            step();
        end
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        checks++;
        if (instr_valid !== 1'b1 || instr !== rdata || imem_req !== 1'b0 ||
            prog_count !== exp || misaligned !== 1'b0) begin
            errors++;
            $display("FAIL fetch_valid: valid=%b instr=%h req=%b pc=%h mis=%b, expected 1 %h 0 %h 0",
                     instr_valid, instr, imem_req, prog_count, misaligned, rdata, exp);
        end
        void'(exp_addr_q.pop_front());
    endtask

    // One handshake cycle with the given next-PC selection; queues the model's address.
    task automatic handshake(input logic [2:0] src, input logic [31:0] tgt_in, input logic [31:0] tv);
        logic        bad;
        logic [31:0] tgt, nxt;
        pc_source   = src;
        jalr_addr   = tgt_in;
        branch_addr = tgt_in;
        jal_addr    = tgt_in;
        mepc        = tgt_in;
        mtvec       = tv;
        nxt = model_next(prog_count, src, tgt_in, tgt_in, tgt_in, tv, tgt_in, bad, tgt);
        exp_addr_q.push_back(nxt);
        if (bad) exp_bad = tgt;
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        pc_source   = 3'bx;
        jalr_addr   = 32'hx; branch_addr = 32'hx; jal_addr = 32'hx;
        mepc        = 32'hx; mtvec       = 32'hx;
        checks++;
        if (misaligned !== bad || bad_addr !== exp_bad) begin
            errors++;
            $display("FAIL handshake_trap: src=%0d mis=%b bad_addr=%h, expected mis=%b bad_addr=%h",
                     src, misaligned, bad_addr, bad, exp_bad);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0; instr_ready = 1'b0;
        pc_source = 3'd0; jalr_addr = 0; branch_addr = 0; jal_addr = 0; mtvec = 0; mepc = 0;
        step(); step();
        rst = 1'b0;
        exp_bad = 32'h0;
        exp_addr_q.delete();
        exp_addr_q.push_back(32'h0);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0 || instr !== 32'h0 ||
            misaligned !== 1'b0 || bad_addr !== 32'h0 || prog_count !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: req=%b addr=%h valid=%b instr=%h mis=%b bad=%h pc=%h",
                     imem_req, imem_addr, instr_valid, instr, misaligned, bad_addr, prog_count);
        end
    endtask

    task automatic test_first_fetch();
        fetch_word(32'h0050_0093, 3);
    endtask

    task automatic test_stall();
        logic [31:0] held_instr, held_pc;
        held_instr = instr;
        held_pc    = 32'h0;
        for (int i = 0; i < 5; i++) begin
            imem_ack   = (i == 2);
            imem_rdata = 32'hCAFE_0000 + i;
            step();
            checks++;
            if (instr !== held_instr || prog_count !== held_pc || imem_req !== 1'b0 ||
                instr_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold: instr=%h pc=%h req=%b valid=%b, expected %h %h 0 1",
                         instr, prog_count, imem_req, instr_valid, held_instr, held_pc);
            end
        end
        imem_ack = 1'b0;
        handshake(3'd0, 32'h0, 32'h0);
        fetch_word(32'h1111_0001, 0);
    endtask

    task automatic test_jumps();
        handshake(3'd3, 32'h100, 32'h0);
        fetch_word(32'h2222_0002, 1);
        checks++;
        if (pc_plus4 !== 32'h104) begin
            errors++;
            $display("FAIL pc_plus4_jal: got %h, expected 00000104", pc_plus4);
        end
        handshake(3'd1, 32'h205, 32'h0);
        fetch_word(32'h3333_0003, 2);
    endtask

    task automatic test_misaligned();
        handshake(3'd2, 32'h102, 32'h80);
        fetch_word(32'h4444_0004, 0);
        // odd jal target with unaligned mtvec traps to the aligned vector
        handshake(3'd3, 32'h301, 32'h83);
        fetch_word(32'h5555_0005, 1);
        // a clean handshake must leave bad_addr untouched
        handshake(3'd5, 32'h400, 32'h0);
        fetch_word(32'h6666_0006, 0);
        // odd mepc also traps
        handshake(3'd5, 32'h501, 32'h200);
        fetch_word(32'h6767_0006, 0);
    endtask

    task automatic test_wrap();
        handshake(3'd3, 32'hFFFF_FFFC, 32'h0);
        fetch_word(32'h7777_0007, 0);
        checks++;
        if (pc_plus4 !== 32'h0) begin
            errors++;
            $display("FAIL pc_plus4_wrap: got %h, expected 00000000", pc_plus4);
        end
        handshake(3'd0, 32'h0, 32'h0);
        fetch_word(32'h8888_0008, 0);
        handshake(3'd7, 32'h900, 32'h0);
        fetch_word(32'h9999_0009, 0);
        handshake(3'd6, 32'h900, 32'h0);
        fetch_word(32'h9A9A_0009, 0);
        handshake(3'd4, 32'h0, 32'h600);
        fetch_word(32'hAAAA_000A, 0);
        handshake(3'd3, 32'h600, 32'h0);
        fetch_word(32'hBBBB_000B, 1);
    endtask

    task automatic test_reset_priority();
        imem_ack = 1'b1; imem_rdata = 32'hCCCC_000C; rst = 1'b1;
        step();
        rst = 1'b0; imem_ack = 1'b0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0 || instr !== 32'h0) begin
            errors++;
            $display("FAIL rst_vs_ack: req=%b addr=%h valid=%b instr=%h, expected 1 0 0 0",
                     imem_req, imem_addr, instr_valid, instr);
        end
        exp_addr_q.delete();
        exp_addr_q.push_back(32'h0);
        exp_bad = 32'h0;
        fetch_word(32'hDDDD_000D, 0);
        pc_source = 3'd3; jal_addr = 32'h700; instr_ready = 1'b1; rst = 1'b1;
        step();
        rst = 1'b0; instr_ready = 1'b0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0 || instr !== 32'h0 ||
            bad_addr !== 32'h0) begin
            errors++;
            $display("FAIL rst_vs_handshake: req=%b addr=%h valid=%b instr=%h bad=%h, expected 1 0 0 0 0",
                     imem_req, imem_addr, instr_valid, instr, bad_addr);
        end
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_stall();
        test_jumps();
        test_misaligned();
        test_wrap();
        test_reset_priority();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
